// File: rtl/btn_scan_pkg.sv
// Shared types and elaboration helpers for the button scan debouncer.
// Consumers: btn_evt_rr, btn_scan_deb.
package btn_scan_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

   // Index width never collapses to zero, even for a single channel.
   function automatic int idw(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/btn_evt_rr.sv
// Round-robin first-set selector: searches pend upward from rr with wrap.
// Purely combinational; any_o is low when no bit is set.
module btn_evt_rr
   import btn_scan_pkg::*;
#(
   parameter  int N   = 4,
   localparam int IDW = idw(N)
) (
   input  logic [N-1:0]   pend_i,
   input  logic [IDW-1:0] rr_i,
   output logic           any_o,
   output logic [IDW-1:0] k_o
);

   int t;

   always_comb begin
      any_o = 1'b0;
      k_o   = '0;
      t     = 0;
      for (int j = 0; j < N; j++) begin
         t = int'(rr_i) + j;
         if (t >= N) begin
            t = t - N;
         end
         if (!any_o && pend_i[t]) begin
            any_o = 1'b1;
            k_o   = IDW'(t);
         end
      end
   end

endmodule

// File: rtl/btn_scan_deb.sv
// Shared-timebase debouncer for N buttons with a round-robin event port.
// Define BTN_SCAN_REL_EVT_EN to also emit release events.
module btn_scan_deb
   import btn_scan_pkg::*;
#(
   parameter  int N             = 4,
   parameter  int CLKS_PER_SMPL = 16,
   parameter  int SMPL_CNT      = 4,
   localparam int IDW           = idw(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   btn,
   output logic [N-1:0]   deb,
   output logic           evt_vld,
   input  logic           evt_rdy,
   output logic [IDW-1:0] evt_id,
   output logic           evt_lvl,
   output logic           ovf
);

   localparam int TW = idw(CLKS_PER_SMPL);
   localparam int CW = clog2(SMPL_CNT + 1);

   localparam logic [TW-1:0]  TMAX = TW'(CLKS_PER_SMPL - 1);
   localparam logic [CW-1:0]  CMAX = CW'(SMPL_CNT - 1);
   localparam logic [IDW-1:0] IMAX = IDW'(N - 1);

   // A scan of N channels must finish before the next tick.
   if (N < 1 || N > 16 || SMPL_CNT < 1 ||
       CLKS_PER_SMPL < N + 1) begin : g_bad_param
      $error("btn_scan_deb: illegal parameter set");
   end

   logic [N-1:0]   s1_q;
   logic [N-1:0]   s_q;
   logic [TW-1:0]  tcnt_q;
   logic           tick;
   state_t         state_q;
   logic [IDW-1:0] idx_q;
   logic [CW-1:0]  c_q [N];
   logic [N-1:0]   deb_q;
   logic [N-1:0]   pend_q;
   logic [N-1:0]   pend_d;
   logic [N-1:0]   plvl_q;
   logic [N-1:0]   plvl_d;
   logic [IDW-1:0] rr_q;
   logic [IDW-1:0] id_q;
   logic           vld_q;
   logic           lvl_q;
   logic           ovf_q;
   logic           ovf_d;

   logic           svc;
   logic           diff;
   logic           flip;
   logic           new_lvl;
   logic           qual;
   logic           raise;
   logic           load;
   logic           any;
   logic [IDW-1:0] k;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s_q  <= '0;
      end else begin
         s1_q <= btn;
         s_q  <= s1_q;
      end
   end

   assign tick = (tcnt_q == TMAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_q <= '0;
      end else if (tick) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (tick) begin
                  state_q <= SCAN;
                  idx_q   <= '0;
               end
            end
            SCAN: begin
               if (idx_q == IMAX) begin
                  state_q <= IDLE;
                  idx_q   <= '0;
               end else begin
                  idx_q <= idx_q + IDW'(1);
               end
            end
         endcase
      end
   end

   assign svc     = (state_q == SCAN);
   assign diff    = (s_q[idx_q] != deb_q[idx_q]);
   assign flip    = svc && diff && (c_q[idx_q] == CMAX);
   assign new_lvl = ~deb_q[idx_q];

`ifdef BTN_SCAN_REL_EVT_EN
   assign qual = 1'b1;
`else
   assign qual = new_lvl;
`endif

   assign raise = flip && qual;

   // Any agreeing sample restarts the stability count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            c_q[i] <= '0;
         end
         deb_q <= '0;
      end else if (svc) begin
         if (!diff) begin
            c_q[idx_q] <= '0;
         end else if (flip) begin
            deb_q[idx_q] <= new_lvl;
            c_q[idx_q]   <= '0;
         end else begin
            c_q[idx_q] <= c_q[idx_q] + CW'(1);
         end
      end
   end

   btn_evt_rr #(
      .N(N)
   ) u_rr (
      .pend_i(pend_q),
      .rr_i  (rr_q),
      .any_o (any),
      .k_o   (k)
   );

   assign load = !vld_q || evt_rdy;

   // A raise landing on the slot being loaded wins without overflow.
   always_comb begin
      pend_d = pend_q;
      plvl_d = plvl_q;
      ovf_d  = 1'b0;
      if (load && any) begin
         pend_d[k] = 1'b0;
      end
      if (raise) begin
         ovf_d = pend_q[idx_q] && !(load && any && (k == idx_q));
         pend_d[idx_q] = 1'b1;
         plvl_d[idx_q] = new_lvl;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
         plvl_q <= '0;
         ovf_q  <= 1'b0;
         vld_q  <= 1'b0;
         id_q   <= '0;
         lvl_q  <= 1'b0;
         rr_q   <= '0;
      end else begin
         pend_q <= pend_d;
         plvl_q <= plvl_d;
         ovf_q  <= ovf_d;
         if (load) begin
            vld_q <= any;
            if (any) begin
               id_q  <= k;
               lvl_q <= plvl_q[k];
               rr_q  <= (k == IMAX) ? '0 : k + IDW'(1);
            end
         end
      end
   end

   assign deb     = deb_q;
   assign evt_vld = vld_q;
   assign evt_id  = id_q;
   assign evt_lvl = lvl_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_btn_scan_deb.sv
// Bench for btn_scan_deb: vector table, directed corner sequences and
// randomized stimulus against a sample-schedule reference model.
module tb_btn_scan_deb;

   localparam int N   = 4;
   localparam int CPS = 16;
   localparam int SC  = 4;
`ifdef BTN_SCAN_REL_EVT_EN
   localparam bit REL = 1'b1;
`else
   localparam bit REL = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] btn = '0;
   logic [N-1:0] deb;
   logic         evt_vld;
   logic         evt_rdy = 1'b0;
   logic [1:0]   evt_id;
   logic         evt_lvl;
   logic         ovf;

   btn_scan_deb #(
      .N(N), .CLKS_PER_SMPL(CPS), .SMPL_CNT(SC)
   ) dut (
      .clk(clk), .rst(rst), .btn(btn), .deb(deb),
      .evt_vld(evt_vld), .evt_rdy(evt_rdy), .evt_id(evt_id),
      .evt_lvl(evt_lvl), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int hs_n   = 0;
   int ovf_n  = 0;
   bit chk_ev = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   // Reference model: channel i is sampled at edges m*CPS+1+i (m>=1)
   // counted from reset release, using the button level two edges earlier.
   int           E = 0;
   logic [N-1:0] hist [64];
   logic [N-1:0] mdeb = '0;
   int           strk [N];
   int           ch;
   logic         smp;
   logic         rv, rv_p = 1'b0;
   int           rid, rid_p = 0;
   logic         rl, rl_p = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         E = 0;
         mdeb = '0;
         rv_p = 1'b0;
         for (int c = 0; c < N; c++) strk[c] = 0;
      end else begin
         E = E + 1;
         hist[E % 64] = btn;
         rv = 1'b0;
         rid = 0;
         rl = 1'b0;
         if (E >= CPS + 1 && ((E - 1) % CPS) < N) begin
            ch = (E - 1) % CPS;
            smp = hist[(E - 2) % 64][ch];
            if (smp == mdeb[ch]) begin
               strk[ch] = 0;
            end else begin
               strk[ch] = strk[ch] + 1;
               if (strk[ch] == SC) begin
                  mdeb[ch] = smp;
                  strk[ch] = 0;
                  if (smp || REL) begin
                     rv = 1'b1;
                     rid = ch;
                     rl = smp;
                  end
               end
            end
         end
         #1;
         if (!rst) begin
            chk("model_deb", 32'(deb), 32'(mdeb));
            if (chk_ev) begin
               chk("model_vld", 32'(evt_vld), 32'(rv_p));
               if (rv_p) begin
                  chk("model_id", 32'(evt_id), 32'(rid_p));
                  chk("model_lvl", 32'(evt_lvl), 32'(rl_p));
               end
               chk("model_ovf", 32'(ovf), 32'd0);
            end
         end
         rv_p = rv;
         rid_p = rid;
         rl_p = rl;
      end
   end

   always @(negedge clk) begin
      if (!rst && evt_vld && evt_rdy) hs_n = hs_n + 1;
      if (!rst && ovf) ovf_n = ovf_n + 1;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      chk_ev = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      hs_n = 0;
      ovf_n = 0;
   endtask

   typedef struct {
      logic [3:0] b;
      int         cyc;
      logic [3:0] deb;
      int         prs;
      int         rel;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int h0;
      int lat;

      tbl[0]  = '{4'b0000, 40, 4'b0000, 0, 0};
      tbl[1]  = '{4'b0100, 80, 4'b0100, 1, 0};
      tbl[2]  = '{4'b0101, 40, 4'b0100, 0, 0};
      tbl[3]  = '{4'b0100, 80, 4'b0100, 0, 0};
      tbl[4]  = '{4'b1100, 80, 4'b1100, 1, 0};
      tbl[5]  = '{4'b0100, 80, 4'b0100, 0, 1};
      tbl[6]  = '{4'b1111, 80, 4'b1111, 3, 0};
      tbl[7]  = '{4'b0110, 40, 4'b1111, 0, 0};
      tbl[8]  = '{4'b1111, 80, 4'b1111, 0, 0};
      tbl[9]  = '{4'b0000, 80, 4'b0000, 0, 4};
      tbl[10] = '{4'b1010, 80, 4'b1010, 2, 0};
      tbl[11] = '{4'b0101, 80, 4'b0101, 2, 2};

      #3;
      chk("rst_deb", 32'(deb), 32'd0);
      chk("rst_vld", 32'(evt_vld), 32'd0);
      chk("rst_id", 32'(evt_id), 32'd0);
      chk("rst_lvl", 32'(evt_lvl), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      @(posedge clk);
      #2;
      do_reset();

      evt_rdy = 1'b1;
      for (int i = 0; i < 12; i++) begin
         btn = tbl[i].b;
         h0 = hs_n;
         wait_cyc(tbl[i].cyc);
         chk($sformatf("tbl%0d_deb", i), 32'(deb), 32'(tbl[i].deb));
         chk($sformatf("tbl%0d_evts", i), 32'(hs_n - h0),
             32'(tbl[i].prs + (REL ? tbl[i].rel : 0)));
      end
      chk("tbl_ovf", 32'(ovf_n), 32'd0);

      btn = '0;
      do_reset();
      evt_rdy = 1'b1;
      btn = 4'b0100;
      lat = 0;
      while (lat < 70 && !deb[2]) begin
         wait_cyc(1);
         lat = lat + 1;
      end
      chk("t1_deb2", 32'(deb[2]), 32'd1);
      wait_cyc(1);
      chk("t1_vld", 32'(evt_vld), 32'd1);
      chk("t1_id", 32'(evt_id), 32'd2);
      chk("t1_lvl", 32'(evt_lvl), 32'd1);
      wait_cyc(1);
      chk("t1_vld_once", 32'(evt_vld), 32'd0);

      btn = '0;
      do_reset();
      evt_rdy = 1'b0;
      btn = 4'b1010;
      wait_cyc(75);
      chk("t3_vld", 32'(evt_vld), 32'd1);
      chk("t3_id_a", 32'(evt_id), 32'd1);
      wait_cyc(25);
      chk("t3_id_b", 32'(evt_id), 32'd1);
      chk("t3_lvl", 32'(evt_lvl), 32'd1);
      evt_rdy = 1'b1;
      wait_cyc(1);
      chk("t3_vld2", 32'(evt_vld), 32'd1);
      chk("t3_id3", 32'(evt_id), 32'd3);
      wait_cyc(1);
      chk("t3_empty", 32'(evt_vld), 32'd0);
      chk("t3_hs", 32'(hs_n), 32'd2);

      btn = '0;
      do_reset();
      evt_rdy = 1'b0;
      btn = 4'b0010;
      wait_cyc(80);
      chk("t4_id1", 32'(evt_id), 32'd1);
      btn = 4'b0011;
      wait_cyc(80);
      chk("t4_noovf", 32'(ovf_n), 32'd0);
      btn = 4'b0010;
      wait_cyc(80);
      if (!REL) begin
         btn = 4'b0011;
         wait_cyc(80);
      end
      chk("t4_ovf_once", 32'(ovf_n), 32'd1);
      chk("t4_vld", 32'(evt_vld), 32'd1);
      chk("t4_idh", 32'(evt_id), 32'd1);
      chk("t4_lvlh", 32'(evt_lvl), 32'd1);
      evt_rdy = 1'b1;
      wait_cyc(1);
      chk("t4_vld2", 32'(evt_vld), 32'd1);
      chk("t4_id0", 32'(evt_id), 32'd0);
      chk("t4_lvl0", 32'(evt_lvl), REL ? 32'd0 : 32'd1);
      wait_cyc(1);
      chk("t4_empty", 32'(evt_vld), 32'd0);

      btn = '0;
      do_reset();
      evt_rdy = 1'b0;
      btn = 4'b1110;
      wait_cyc(100);
      chk("t6_pre_vld", 32'(evt_vld), 32'd1);
      for (int n = 0; n < 20 && (E % CPS) != 1; n++) wait_cyc(1);
      chk("t6_in_scan", 32'(E % CPS), 32'd1);
      rst = 1'b1;
      chk_ev = 1'b0;
      #1;
      chk("t6_deb", 32'(deb), 32'd0);
      chk("t6_vld", 32'(evt_vld), 32'd0);
      chk("t6_id", 32'(evt_id), 32'd0);
      chk("t6_lvl", 32'(evt_lvl), 32'd0);
      chk("t6_ovf", 32'(ovf), 32'd0);
      btn = '0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      evt_rdy = 1'b1;
      hs_n = 0;
      wait_cyc(100);
      chk("t6_stale", 32'(hs_n), 32'd0);
      btn = 4'b0001;
      lat = 0;
      while (lat < 80 && !deb[0]) begin
         wait_cyc(1);
         lat = lat + 1;
      end
      chk("t6_lat_lo", 32'(lat >= 49), 32'd1);
      chk("t6_lat_hi", 32'(lat <= 70), 32'd1);

      btn = '0;
      do_reset();
      evt_rdy = 1'b1;
      chk_ev = 1'b1;
      for (int n = 0; n < 2500; n++) begin
         wait_cyc(1);
         if ($urandom_range(0, 23) == 0)
            btn[$urandom_range(0, N - 1)] ^= 1'b1;
      end
      chk_ev = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
